md_sequencer: RTL and testbench
===============================

# md_sequencer

Multiply/divide sequencer for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and runs multi-cycle operations against the HI/LO register pair. While an operation is in flight it raises a busy/stall indication that the pipeline hazard logic uses to hold any later HI/LO-touching instruction in decode. The block sits beside the ALU in the execute stage and owns HI and LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- start  in  1  execute-stage request valid, one-cycle pulse per instruction
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6/7 reserved (no effect)
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- md_use_d  in  1  decode-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO
- busy  out  1  multi-cycle operation in flight
- stall  out  1  hold decode: md_use_d & (busy | start_mc), where start_mc = start & op∈{0..3}
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- FSM states: IDLE, RUN.
- IDLE, start & op∈{0,1,2,3}:
  - latch src_a, src_b, and op.
  - load the down-counter with MULT_CYCLES or DIV_CYCLES.
  - go to RUN.
- IDLE, start & op=4: hi←src_a next edge; stay IDLE. op=5: lo←src_a.
- IDLE, start & op∈{6,7}: no state change.
- RUN: decrement the counter each cycle. When the counter reaches 1, write the result to hi/lo at that edge and go to IDLE.
- Start while in RUN is ignored entirely (no latch, no HI/LO write). The pipeline never issues it because stall prevents it.
- Arithmetic (results from latched operands):
  - MULT: signed 32×32→64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32×32→64.
  - DIV: signed; lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. Overflow case 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned; lo = quotient, hi = remainder.
  - Divide by zero (src_b=0, DIV or DIVU): runs the full DIV_CYCLES, then hi and lo are left unchanged.
- The result may be computed combinationally or iteratively. Only the write instant is architecturally visible; hi/lo must hold their old values throughout RUN.
- busy = (state==RUN).
- stall is combinational from md_use_d, busy, start, and op, so it asserts in the same cycle the multi-cycle op is issued.

## Timing
- Reset (reset=0 at an edge):
  - state←IDLE, counter←0, busy=0, hi=0, lo=0.
  - stall then depends only on md_use_d & start_mc.
  - A reset mid-RUN aborts the operation and does not write the result.
- Issue at edge E0 (start sampled):
  - busy=1 from E0 through E0+N, where N = MULT_CYCLES or DIV_CYCLES.
  - busy=0 after edge E0+N; hi/lo show the result after E0+N.
  - Total: N cycles of busy. An MFHI in decode in cycle E0+N reads the new value.
- A start in the same cycle that busy falls (after E0+N) is accepted normally. Back-to-back operations therefore have zero dead cycles.
- MTHI/MTLO take 1 cycle and never assert busy.
- Simultaneous md_use_d and start_mc while IDLE: stall=1 in that cycle.

## Test plan
- Reset then idle:
  - Stimulus: reset=0 for 2 cycles, then reset=1.
  - Required: hi=lo=0, busy=0, stall=0 with md_use_d=0.
- MULT signed:
  - Stimulus: src_a=0xFFFFFFFE (−2), src_b=0x00000003.
  - Required: busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU:
  - Stimulus: src_a=src_b=0xFFFFFFFF.
  - Required: hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV negative dividend:
  - Stimulus: src_a=−7 (0xFFFFFFF9), src_b=2.
  - Required: after 10 busy cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- Divide by zero, then stall:
  - Stimulus: preload hi=0x1111 and lo=0x2222 via MTHI/MTLO; DIVU with src_b=0; hold md_use_d=1 throughout.
  - Required: hi/lo unchanged; busy for 10 cycles; stall=1 from the issue cycle through the last busy cycle, 0 the cycle after.
- Reset mid-operation and ignored start:
  - Stimulus: issue DIV 100/7; at busy cycle 3 pulse start with MTLO 0xAAAA; at busy cycle 5 assert reset=0.
  - Required: lo never becomes 0xAAAA; after reset hi=lo=0 and busy=0. A subsequent MULT 3×4 gives lo=12, hi=0.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer signal bundle.
// The master is the pipeline side that issues requests. The slave is md_sequencer.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, md_use_d,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, md_use_d,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer. This block owns HI/LO.
// It runs MULT/MULTU/DIV/DIVU as fixed-latency operations and applies MTHI/MTLO in one cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepting requests; MTHI/MTLO write immediately
// RUN   | multi-cycle op in flight; counter counts down to the write edge
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [CW-1:0] cnt;
  logic [1:0]   op_q;
  logic [31:0]  a_q;
  logic [31:0]  b_q;
  logic         busy_q;
  logic [31:0]  hi_q;
  logic [31:0]  lo_q;

  logic         start_mc;
  logic [63:0]  prod_s;
  logic [63:0]  prod_u;
  logic [31:0]  mag_a;
  logic [31:0]  mag_b;
  logic [31:0]  div_b;
  logic [31:0]  quo_u;
  logic [31:0]  rem_u;
  logic [31:0]  mag_q;
  logic [31:0]  mag_r;
  logic [31:0]  quo_s;
  logic [31:0]  rem_s;
  logic         res_we;
  logic [31:0]  res_hi;
  logic [31:0]  res_lo;

  // Multi-cycle request qualifier; reserved and MTHI/MTLO opcodes never stall.
  assign start_mc = md.start & (md.op[2] == 1'b0);

  // Stall must hold decode in the same cycle the op is issued, so it is not registered.
  assign md.stall = md.md_use_d & (busy_q | start_mc);
  assign md.busy  = busy_q;
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

  // Result datapath from the latched operands. It is consumed only on the final RUN edge.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'h0, a_q} * {32'h0, b_q};

    // The divisor is forced nonzero so a zero divide never propagates X; that result is discarded anyway.
    div_b  = (b_q == 32'h0) ? 32'h1 : b_q;
    quo_u  = a_q / div_b;
    rem_u  = a_q % div_b;

    // Signed divide on magnitudes. 0x80000000 stays 0x80000000 as an unsigned magnitude.
    // This makes the MIN/-1 case fall out as quotient 0x80000000 with remainder 0.
    mag_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    mag_b  = div_b[31] ? (~div_b + 32'd1) : div_b;
    mag_q  = mag_a / mag_b;
    mag_r  = mag_a % mag_b;
    quo_s  = (a_q[31] ^ b_q[31]) ? (~mag_q + 32'd1) : mag_q;
    rem_s  = a_q[31] ? (~mag_r + 32'd1) : mag_r;

    res_we = 1'b1;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      2'd0: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      2'd1: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      2'd2: begin
        res_we = (b_q != 32'h0);
        res_hi = rem_s;
        res_lo = quo_s;
      end
      default: begin
        res_we = (b_q != 32'h0);
        res_hi = rem_u;
        res_lo = quo_u;
      end
    endcase
  end

  // Sequencer FSM: issue, countdown, and the HI/LO write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= 2'd0;
      a_q    <= 32'h0;
      b_q    <= 32'h0;
      busy_q <= 1'b0;
      hi_q   <= 32'h0;
      lo_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (md.start) begin
            case (md.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q   <= md.op[1:0];
                a_q    <= md.src_a;
                b_q    <= md.src_b;
                cnt    <= md.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                busy_q <= 1'b1;
                state  <= RUN;
              end
              3'd4:    hi_q <= md.src_a;
              3'd5:    lo_q <= md.src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Testbench for md_sequencer.
// Directed test-plan steps run first, followed by random operations.
// Each operation is checked against an arithmetic reference model.
module tb_md_sequencer;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  md_sequencer_if mdif ();

  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference HI/LO after an operation, from the architectural definition of each opcode.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    nh = exp_hi;
    nl = exp_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; end
      3'd1: begin up = ua * ub; nh = up[63:32]; nl = up[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
      3'd3: if (b != 0) begin uq = ua / ub; ur = ua % ub; nh = ur[31:0]; nl = uq[31:0]; end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
  endtask

  // Issue one request from a negedge and follow it to completion.
  // The task returns on the negedge where the next request may issue.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
    logic [31:0] nh, nl;
    int n;
    int cyc;
    model(op, a, b, nh, nl);
    mdif.start    = 1'b1;
    mdif.op       = op;
    mdif.src_a    = a;
    mdif.src_b    = b;
    mdif.md_use_d = use_d;
    #1;
    check("stall_issue", {31'h0, mdif.stall}, {31'h0, use_d & (op < 3'd4)});
    @(negedge clk);
    mdif.start = 1'b0;
    if (op < 3'd4) begin
      n   = (op < 3'd2) ? MC : DC;
      cyc = 0;
      while (mdif.busy === 1'b1 && cyc < 100) begin
        if (mdif.hi !== exp_hi || mdif.lo !== exp_lo || mdif.stall !== use_d)
          check("hold_during_run", {mdif.hi ^ exp_hi ^ mdif.lo ^ exp_lo}, {31'h0, mdif.stall ^ use_d});
        cyc++;
        @(negedge clk);
      end
      check("busy_cycles", cyc, n);
      check("stall_after", {31'h0, mdif.stall}, 32'h0);
    end else begin
      check("busy_single", {31'h0, mdif.busy}, 32'h0);
    end
    exp_hi = nh;
    exp_lo = nl;
    check("hi", mdif.hi, exp_hi);
    check("lo", mdif.lo, exp_lo);
    mdif.md_use_d = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          seen_aaaa;
    total = 0;
    bad   = 0;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    reset = 1'b0;
    mdif.start = 1'b0;
    mdif.op = 3'd0;
    mdif.src_a = 32'h0;
    mdif.src_b = 32'h0;
    mdif.md_use_d = 1'b0;
    @(negedge clk);
    do_reset();
    check("rst_hi", mdif.hi, 32'h0);
    check("rst_lo", mdif.lo, 32'h0);
    check("rst_busy", {31'h0, mdif.busy}, 32'h0);
    check("rst_stall", {31'h0, mdif.stall}, 32'h0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check("mult_hi", mdif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mdif.lo, 32'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_hi", mdif.hi, 32'hFFFF_FFFE);
    check("multu_lo", mdif.lo, 32'h0000_0001);

    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check("div_hi", mdif.hi, 32'hFFFF_FFFF);
    check("div_lo", mdif.lo, 32'hFFFF_FFFD);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    check("divovf_hi", mdif.hi, 32'h0);
    check("divovf_lo", mdif.lo, 32'h8000_0000);

    run_op(3'd4, 32'h0000_1111, 32'h0, 1'b0);
    run_op(3'd5, 32'h0000_2222, 32'h0, 1'b0);
    run_op(3'd3, 32'h1234_5678, 32'h0, 1'b1);
    check("div0_hi", mdif.hi, 32'h0000_1111);
    check("div0_lo", mdif.lo, 32'h0000_2222);

    run_op(3'd6, 32'hDEAD_BEEF, 32'h1, 1'b1);
    run_op(3'd7, 32'hDEAD_BEEF, 32'h1, 1'b0);

    // Abort test: an ignored MTLO arrives mid-RUN, and then reset hits mid-RUN.
    seen_aaaa = 0;
    mdif.start = 1'b1;
    mdif.op = 3'd2;
    mdif.src_a = 32'd100;
    mdif.src_b = 32'd7;
    @(negedge clk);
    mdif.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (mdif.lo === 32'h0000_AAAA) seen_aaaa++;
      check("abort_busy", {31'h0, mdif.busy}, 32'h1);
      if (c == 3) begin
        mdif.start = 1'b1;
        mdif.op = 3'd5;
        mdif.src_a = 32'h0000_AAAA;
      end else begin
        mdif.start = 1'b0;
      end
      if (c == 5) reset = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    if (mdif.lo === 32'h0000_AAAA) seen_aaaa++;
    check("no_aaaa", seen_aaaa, 0);
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    check("abort_hi", mdif.hi, 32'h0);
    check("abort_lo", mdif.lo, 32'h0);
    check("abort_busy0", {31'h0, mdif.busy}, 32'h0);
    run_op(3'd0, 32'd3, 32'd4, 1'b0);
    check("post_hi", mdif.hi, 32'h0);
    check("post_lo", mdif.lo, 32'd12);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
